// File: rtl/rtc_burst_writer.sv
// RTC burst writer: drives a multiplexed address/data RTC bus with one
// cs_n/ad_n/wr_n slot of T_END+1 clocks per byte, writing burst_len
// consecutive registers starting at direccion.
// Optional build macro RTC_BCD_CHECK_EN: reject bursts that carry any
// non-BCD nibble, flagging error_bcd and finishing without bus activity.
module rtc_burst_writer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned T_ADDR    = 7,
  parameter int unsigned T_DATA    = 29,
  parameter int unsigned T_END     = 42
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable_escribir,
  input  logic [DATA_W-1:0]             direccion,
  input  logic [$clog2(MAX_BURST+1)-1:0] burst_len,
  input  logic [MAX_BURST*DATA_W-1:0]   dato_escritura,
  input  logic                          reset_listo_escritura,
  output logic [DATA_W-1:0]             bus_out_escribir,
  output logic                          bus_oe,
  output logic                          cs_n,
  output logic                          ad_n,
  output logic                          wr_n,
  output logic                          ocupado,
  output logic                          listo_escribir,
  output logic                          error_bcd
);

  localparam int unsigned LenW = $clog2(MAX_BURST + 1);
  localparam int unsigned CntW = $clog2(T_END + 1);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntAddr   = CntW'(T_ADDR);
  localparam logic [CntW-1:0] CntData   = CntW'(T_DATA);
  localparam logic [CntW-1:0] CntDataM1 = CntW'(T_DATA - 1);
  localparam logic [CntW-1:0] CntEnd    = CntW'(T_END);
  localparam logic [CntW-1:0] CntEndM1  = CntW'(T_END - 1);
  localparam logic [CntW-1:0] WrAddrLo  = CntW'(T_ADDR + 1);
  localparam logic [CntW-1:0] WrAddrHi  = CntW'(T_ADDR + 6);
  localparam logic [CntW-1:0] WrDataLo  = CntW'(T_DATA + 1);
  localparam logic [CntW-1:0] WrDataHi  = CntW'(T_DATA + 6);
  localparam logic [LenW-1:0] LenMax    = LenW'(MAX_BURST);
  localparam logic [LenW-1:0] LenOne    = LenW'(1);

  // Slot timing must leave room for both six-cycle write strobes.
  if (!((T_ADDR + 7 < T_DATA) && (T_DATA + 7 < T_END) && (MAX_BURST >= 1)))
  begin : g_param_check
    $fatal(1, "rtc_burst_writer: illegal slot timing parameters");
  end

  typedef enum logic [1:0] {StIdle, StSlot, StDone} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [LenW-1:0]               idx_q, idx_d;
  logic [LenW-1:0]               len_q, len_d;
  logic [DATA_W-1:0]             addr_q, addr_d;
  logic [MAX_BURST*DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]             bus_q;
  logic                          listo_q, listo_d;
  logic                          start_ok;
  logic                          in_slot;
  logic [DATA_W-1:0]             cur_byte;

`ifdef RTC_BCD_CHECK_EN
  logic err_q, err_d;
  logic bcd_bad;

  // Any nibble above 9 in the bytes actually being written.
  function automatic logic bcd_violation(input logic [MAX_BURST*DATA_W-1:0] data,
                                         input logic [LenW-1:0]             len);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(MAX_BURST); i++) begin
      if (i < int'(len)) begin
        for (int j = 0; j < int'(DATA_W / 4); j++) begin
          if (data[i*int'(DATA_W) + j*4 +: 4] > 4'd9) bad = 1'b1;
        end
      end
    end
    return bad;
  endfunction

  assign bcd_bad   = bcd_violation(dato_escritura, burst_len);
  assign error_bcd = err_q;
`else
  assign error_bcd = 1'b0;
`endif

  assign start_ok = enable_escribir && (burst_len != '0) && (burst_len <= LenMax);
  assign in_slot  = (state_q == StSlot);
  assign cur_byte = data_q[int'(idx_q)*int'(DATA_W) +: DATA_W];

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bus_q   <= '0;
      listo_q <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bus_q   <= bus_out_escribir;
      listo_q <= listo_d;
`ifdef RTC_BCD_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: accept a burst, walk byte slots, wait for done-clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    addr_d  = addr_q;
    data_d  = data_q;
    listo_d = listo_q;
`ifdef RTC_BCD_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          addr_d  = direccion;
          len_d   = burst_len;
          data_d  = dato_escritura;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StSlot;
`ifdef RTC_BCD_CHECK_EN
          if (bcd_bad) begin
            state_d = StDone;
            listo_d = 1'b1;
            err_d   = 1'b1;
          end
`endif
        end
      end
      StSlot: begin
        if (cnt_q == CntEnd) begin
          cnt_d = '0;
          if ((idx_q + LenOne) < len_q) begin
            idx_d  = idx_q + LenOne;
            addr_d = addr_q + DATA_W'(1);
          end else begin
            state_d = StDone;
            listo_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDone: begin
        if (reset_listo_escritura) begin
          state_d = StIdle;
          listo_d = 1'b0;
`ifdef RTC_BCD_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes decode straight from state and count so reset clears them at once.
  always_comb begin
    cs_n             = 1'b1;
    ad_n             = 1'b1;
    wr_n             = 1'b1;
    bus_oe           = 1'b0;
    ocupado          = in_slot;
    listo_escribir   = listo_q;
    bus_out_escribir = bus_q;
    if (in_slot) begin
      cs_n   = !((cnt_q >= CntOne) && (cnt_q <= CntEndM1));
      ad_n   = !((cnt_q >= CntAddr) && (cnt_q <= CntDataM1));
      wr_n   = !(((cnt_q >= WrAddrLo) && (cnt_q <= WrAddrHi)) ||
                 ((cnt_q >= WrDataLo) && (cnt_q <= WrDataHi)));
      bus_oe = (cnt_q >= CntAddr) && (cnt_q <= CntEndM1);
      // Bus value is presented in the load cycle itself and held afterwards.
      if (cnt_q == CntAddr) begin
        bus_out_escribir = addr_q;
      end else if (cnt_q == CntData) begin
        bus_out_escribir = cur_byte;
      end
    end
  end

endmodule

// File: tb/tb_rtc_burst_writer.sv
// Directed self-checking bench for rtc_burst_writer with default parameters.
module tb_rtc_burst_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_escribir = 1'b0;
  logic [7:0]  direccion = '0;
  logic [2:0]  burst_len = '0;
  logic [31:0] dato_escritura = '0;
  logic        reset_listo_escritura = 1'b0;
  logic [7:0]  bus_out_escribir;
  logic        bus_oe, cs_n, ad_n, wr_n, ocupado, listo_escribir, error_bcd;

  int tests_run = 0;
  int fails = 0;

  rtc_burst_writer dut (
    .clk                   (clk),
    .reset                 (reset),
    .enable_escribir       (enable_escribir),
    .direccion             (direccion),
    .burst_len             (burst_len),
    .dato_escritura        (dato_escritura),
    .reset_listo_escritura (reset_listo_escritura),
    .bus_out_escribir      (bus_out_escribir),
    .bus_oe                (bus_oe),
    .cs_n                  (cs_n),
    .ad_n                  (ad_n),
    .wr_n                  (wr_n),
    .ocupado               (ocupado),
    .listo_escribir        (listo_escribir),
    .error_bcd             (error_bcd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start pulse; on return the DUT has taken the start edge.
  task automatic start(input logic [7:0] a, input logic [2:0] n, input logic [31:0] d);
    direccion       = a;
    burst_len       = n;
    dato_escritura  = d;
    enable_escribir = 1'b1;
    tick();
    enable_escribir = 1'b0;
  endtask

  task automatic clear_done();
    reset_listo_escritura = 1'b1;
    tick();
    reset_listo_escritura = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    tests_run++;
    if ({bus_out_escribir, bus_oe, cs_n, ad_n, wr_n, ocupado, listo_escribir, error_bcd}
        !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got bus=%h oe=%b cs=%b ad=%b wr=%b busy=%b listo=%b err=%b",
               bus_out_escribir, bus_oe, cs_n, ad_n, wr_n, ocupado, listo_escribir, error_bcd);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic exp_cs, exp_ad, exp_wr, exp_oe;
    start(8'h21, 3'd1, 32'h0000_0045);
    for (int c = 0; c <= 42; c++) begin
      exp_cs = !(c >= 1 && c <= 41);
      exp_ad = !(c >= 7 && c <= 28);
      exp_wr = !((c >= 8 && c <= 13) || (c >= 30 && c <= 35));
      exp_oe = (c >= 7 && c <= 41);
      tests_run++;
      if ({cs_n, ad_n, wr_n, bus_oe, ocupado} !== {exp_cs, exp_ad, exp_wr, exp_oe, 1'b1}) begin
        fails++;
        $display("FAIL single_strobes c=%0d: got cs/ad/wr/oe/busy=%b%b%b%b%b want %b%b%b%b1",
                 c, cs_n, ad_n, wr_n, bus_oe, ocupado, exp_cs, exp_ad, exp_wr, exp_oe);
      end
      if (c == 7 || c == 28 || c == 29 || c == 40) begin
        tests_run++;
        if (bus_out_escribir !== ((c < 29) ? 8'h21 : 8'h45)) begin
          fails++;
          $display("FAIL single_bus c=%0d: got %h want %h", c, bus_out_escribir,
                   (c < 29) ? 8'h21 : 8'h45);
        end
      end
      tick();
    end
    tests_run++;
    if ({listo_escribir, ocupado, cs_n, bus_oe, error_bcd} !== 5'b10100) begin
      fails++;
      $display("FAIL single_done: got listo/busy/cs/oe/err=%b%b%b%b%b want 10100",
               listo_escribir, ocupado, cs_n, bus_oe, error_bcd);
    end
    clear_done();
    tests_run++;
    if (listo_escribir !== 1'b0) begin
      fails++;
      $display("FAIL single_clear: got listo=%b want 0", listo_escribir);
    end
  endtask

  task automatic test_multi();
    logic [7:0] exp_addr [3];
    logic [7:0] exp_data [3];
    exp_addr = '{8'hFE, 8'hFF, 8'h00};
    exp_data = '{8'h11, 8'h22, 8'h33};
    start(8'hFE, 3'd3, 32'h0033_2211);
    for (int t = 0; t <= 129; t++) begin
      if (t == 129) begin
        tests_run++;
        if ({listo_escribir, ocupado} !== 2'b10) begin
          fails++;
          $display("FAIL multi_done: got listo/busy=%b%b want 10", listo_escribir, ocupado);
        end
      end else begin
        tests_run++;
        if ({listo_escribir, ocupado} !== 2'b01) begin
          fails++;
          $display("FAIL multi_busy t=%0d: got listo/busy=%b%b want 01", t, listo_escribir, ocupado);
        end
        if (t % 43 == 7) begin
          tests_run++;
          if (bus_out_escribir !== exp_addr[t/43]) begin
            fails++;
            $display("FAIL multi_addr byte=%0d: got %h want %h", t/43, bus_out_escribir,
                     exp_addr[t/43]);
          end
        end
        if (t % 43 == 29) begin
          tests_run++;
          if (bus_out_escribir !== exp_data[t/43]) begin
            fails++;
            $display("FAIL multi_data byte=%0d: got %h want %h", t/43, bus_out_escribir,
                     exp_data[t/43]);
          end
        end
      end
      if (t < 129) tick();
    end
    clear_done();
  endtask

  task automatic test_ignore();
    start(8'h10, 3'd1, 32'h0000_0099);
    for (int t = 0; t < 5; t++) tick();
    // Stray start mid-slot must not relatch anything.
    start(8'h55, 3'd2, 32'h0000_7777);
    reset_listo_escritura = 1'b1;
    tick();
    reset_listo_escritura = 1'b0;
    tests_run++;
    if (bus_out_escribir !== 8'h10) begin
      fails++;
      $display("FAIL ignore_slot_addr: got %h want 10", bus_out_escribir);
    end
    for (int t = 7; t < 29; t++) tick();
    tests_run++;
    if (bus_out_escribir !== 8'h99) begin
      fails++;
      $display("FAIL ignore_slot_data: got %h want 99", bus_out_escribir);
    end
    for (int t = 29; t < 43; t++) tick();
    tests_run++;
    if ({listo_escribir, ocupado} !== 2'b10) begin
      fails++;
      $display("FAIL ignore_len: got listo/busy=%b%b want 10", listo_escribir, ocupado);
    end
    start(8'h30, 3'd1, 32'h0000_0001);
    tests_run++;
    if ({listo_escribir, ocupado, cs_n} !== 3'b101) begin
      fails++;
      $display("FAIL ignore_done: got listo/busy/cs=%b%b%b want 101", listo_escribir, ocupado, cs_n);
    end
    clear_done();
    start(8'h30, 3'd1, 32'h0000_0001);
    tests_run++;
    if ({listo_escribir, ocupado} !== 2'b01) begin
      fails++;
      $display("FAIL restart: got listo/busy=%b%b want 01", listo_escribir, ocupado);
    end
    for (int t = 0; t < 43; t++) tick();
    clear_done();
  endtask

  task automatic test_reset_mid();
    start(8'h40, 3'd2, 32'h0000_2211);
    for (int t = 0; t < 63; t++) tick();
    tests_run++;
    if ({ocupado, cs_n, bus_oe} !== 3'b101) begin
      fails++;
      $display("FAIL abort_pre: got busy/cs/oe=%b%b%b want 101", ocupado, cs_n, bus_oe);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus_out_escribir, bus_oe, cs_n, ad_n, wr_n, ocupado, listo_escribir, error_bcd}
        !== {8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_outputs: got bus=%h oe=%b cs=%b ad=%b wr=%b busy=%b listo=%b",
               bus_out_escribir, bus_oe, cs_n, ad_n, wr_n, ocupado, listo_escribir);
    end
    #1;
    reset = 1'b1;
    for (int t = 0; t < 60; t++) tick();
    tests_run++;
    if ({listo_escribir, ocupado, cs_n} !== 3'b001) begin
      fails++;
      $display("FAIL abort_after: got listo/busy/cs=%b%b%b want 001", listo_escribir, ocupado, cs_n);
    end
  endtask

  task automatic test_bad_len();
    start(8'h01, 3'd0, 32'h0000_0001);
    tests_run++;
    if ({ocupado, cs_n, listo_escribir} !== 3'b010) begin
      fails++;
      $display("FAIL len_zero: got busy/cs/listo=%b%b%b want 010", ocupado, cs_n, listo_escribir);
    end
    start(8'h01, 3'd5, 32'h0000_0001);
    tick();
    tests_run++;
    if ({ocupado, cs_n, listo_escribir} !== 3'b010) begin
      fails++;
      $display("FAIL len_over: got busy/cs/listo=%b%b%b want 010", ocupado, cs_n, listo_escribir);
    end
  endtask

  task automatic test_bcd();
    start(8'h02, 3'd1, 32'h0000_005A);
`ifdef RTC_BCD_CHECK_EN
    tests_run++;
    if ({error_bcd, listo_escribir, ocupado, cs_n} !== 4'b1101) begin
      fails++;
      $display("FAIL bcd_flag: got err/listo/busy/cs=%b%b%b%b want 1101",
               error_bcd, listo_escribir, ocupado, cs_n);
    end
    clear_done();
    tests_run++;
    if ({error_bcd, listo_escribir} !== 2'b00) begin
      fails++;
      $display("FAIL bcd_clear: got err/listo=%b%b want 00", error_bcd, listo_escribir);
    end
`else
    for (int t = 0; t < 29; t++) tick();
    tests_run++;
    if ({bus_out_escribir, error_bcd, ocupado} !== {8'h5A, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL bcd_unchecked: got bus=%h err=%b busy=%b want 5a 0 1",
               bus_out_escribir, error_bcd, ocupado);
    end
    for (int t = 29; t < 43; t++) tick();
    clear_done();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_ignore();
    test_reset_mid();
    test_bad_len();
    test_bcd();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
